fifo_sc_ext: RTL and testbench

Single-clock FIFO with asymmetric write/read widths, selectable standard or first-word-fall-through read mode, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags. It is the single-clock-domain FIFO for datapaths that need width conversion plus flow-control watermarks, without gray-code pointer synchronisation.

---
 rtl/fifo_sc_ext.sv | 140 ++++++++++++++
 tb/tb_fifo_sc_ext.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sc_ext.sv
// rtl/fifo_sc_ext.sv - single-clock FIFO with width conversion, FWFT option, watermarks and sticky errors
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i, clr_err_i      pointer/count clear, sticky error clear
//   wr_en_i, wr_data_i      write request and I_WIDTH word
//   wr_full_o, wr_free_o    no room for a write word / free space in write words
//   wr_afull_o, wr_ovf_o    almost full / sticky write-while-full
//   rd_en_i                 read request (pop)
//   rd_data_o, rd_valid_o   O_WIDTH read word and its valid
//   rd_empty_o, rd_avail_o  no complete read word / complete read words stored
//   rd_aempty_o, rd_udf_o   almost empty / sticky read-while-empty

module fifo_sc_ext #(
  parameter int I_WIDTH  = 64,
  parameter int I_DEPTH  = 32,
  parameter int O_WIDTH  = 32,
  parameter int O_DEPTH  = 64,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       clr_err_i,
  input  logic                       wr_en_i,
  input  logic [I_WIDTH-1:0]         wr_data_i,
  output logic                       wr_full_o,
  output logic [$clog2(I_DEPTH):0]   wr_free_o,
  output logic                       wr_afull_o,
  output logic                       wr_ovf_o,
  input  logic                       rd_en_i,
  output logic [O_WIDTH-1:0]         rd_data_o,
  output logic                       rd_valid_o,
  output logic                       rd_empty_o,
  output logic [$clog2(O_DEPTH):0]   rd_avail_o,
  output logic                       rd_aempty_o,
  output logic                       rd_udf_o
);

  // Storage is kept in units of the narrower word (one "slot"); a wide
  // word occupies several consecutive slots, lowest slice at lowest slot.
  localparam int NW  = (I_WIDTH < O_WIDTH) ? I_WIDTH : O_WIDTH;
  localparam int WS  = I_WIDTH / NW;
  localparam int RS  = O_WIDTH / NW;
  localparam int G   = (I_DEPTH > O_DEPTH) ? I_DEPTH : O_DEPTH;
  localparam int AW  = $clog2(G);
  localparam int CW  = AW + 1;
  localparam int FW  = $clog2(I_DEPTH) + 1;
  localparam int VW  = $clog2(O_DEPTH) + 1;
  localparam int WSH = $clog2(WS);
  localparam int RSH = $clog2(RS);

  logic [NW-1:0]      mem [G];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      free_words;
  logic [CW-1:0]      avail_words;
  logic [O_WIDTH-1:0] rd_word;
  logic               wr_acc;
  logic               rd_acc;

  // Slot counts convert to word counts by shifting, since ratios are powers of 2.
  assign free_words  = (CW'(G) - cnt) >> WSH;
  assign avail_words = cnt >> RSH;
  assign wr_free_o   = free_words[FW-1:0];
  assign rd_avail_o  = avail_words[VW-1:0];
  assign wr_full_o   = (wr_free_o == '0);
  assign rd_empty_o  = (rd_avail_o == '0);
  assign wr_afull_o  = (32'(wr_free_o) <= AF_LEVEL);
  assign rd_aempty_o = (32'(rd_avail_o) <= AE_LEVEL);

  // Flush swallows concurrent traffic, so it also masks acceptance.
  assign wr_acc = wr_en_i & ~wr_full_o & ~flush_i;
  assign rd_acc = rd_en_i & ~rd_empty_o & ~flush_i;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < RS; k++) begin
      rd_word[k*NW +: NW] = mem[rd_ptr + AW'(k)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int k = 0; k < WS; k++) begin
        mem[wr_ptr + AW'(k)] <= wr_data_i[k*NW +: NW];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(WS);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(RS);
      cnt <= cnt + (wr_acc ? CW'(WS) : '0) - (rd_acc ? CW'(RS) : '0);
    end
  end

  // Sticky errors: a new set in the same cycle as clr_err_i wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ovf_o <= 1'b0;
      rd_udf_o <= 1'b0;
    end else begin
      if (wr_en_i && wr_full_o && !flush_i) wr_ovf_o <= 1'b1;
      else if (clr_err_i)                   wr_ovf_o <= 1'b0;
      if (rd_en_i && rd_empty_o && !flush_i) rd_udf_o <= 1'b1;
      else if (clr_err_i)                    rd_udf_o <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data_o  = rd_word;
    assign rd_valid_o = ~rd_empty_o;
  end else begin : g_std
    logic [O_WIDTH-1:0] data_q;
    logic               valid_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) data_q <= rd_word;
      end
    end

    assign rd_data_o  = data_q;
    assign rd_valid_o = valid_q;
  end

endmodule

// File: tb/tb_fifo_sc_ext.sv
// tb/tb_fifo_sc_ext.sv - self-checking bench for fifo_sc_ext (64->32 standard and 32->64 FWFT)

module tb_fifo_sc_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  // DUT A: 64b write, 32b read, standard read mode
  logic        a_flush = 0, a_clr = 0, a_wr_en = 0, a_rd_en = 0;
  logic [63:0] a_wd = '0;
  logic        a_full, a_afull, a_ovf, a_valid, a_empty, a_aempty, a_udf;
  logic [5:0]  a_free;
  logic [6:0]  a_avail;
  logic [31:0] a_data;

  // DUT B: 32b write, 64b read, first-word-fall-through
  logic        b_flush = 0, b_clr = 0, b_wr_en = 0, b_rd_en = 0;
  logic [31:0] b_wd = '0;
  logic        b_full, b_afull, b_ovf, b_valid, b_empty, b_aempty, b_udf;
  logic [6:0]  b_free;
  logic [5:0]  b_avail;
  logic [63:0] b_data;

  fifo_sc_ext #(.I_WIDTH(64), .I_DEPTH(32), .O_WIDTH(32), .O_DEPTH(64), .FWFT(0),
                .AF_LEVEL(4), .AE_LEVEL(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .clr_err_i(a_clr),
    .wr_en_i(a_wr_en), .wr_data_i(a_wd), .wr_full_o(a_full), .wr_free_o(a_free),
    .wr_afull_o(a_afull), .wr_ovf_o(a_ovf), .rd_en_i(a_rd_en), .rd_data_o(a_data),
    .rd_valid_o(a_valid), .rd_empty_o(a_empty), .rd_avail_o(a_avail),
    .rd_aempty_o(a_aempty), .rd_udf_o(a_udf)
  );

  fifo_sc_ext #(.I_WIDTH(32), .I_DEPTH(64), .O_WIDTH(64), .O_DEPTH(32), .FWFT(1),
                .AF_LEVEL(4), .AE_LEVEL(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .clr_err_i(b_clr),
    .wr_en_i(b_wr_en), .wr_data_i(b_wd), .wr_full_o(b_full), .wr_free_o(b_free),
    .wr_afull_o(b_afull), .wr_ovf_o(b_ovf), .rd_en_i(b_rd_en), .rd_data_o(b_data),
    .rd_valid_o(b_valid), .rd_empty_o(b_empty), .rd_avail_o(b_avail),
    .rd_aempty_o(b_aempty), .rd_udf_o(b_udf)
  );

  // Model: each FIFO is a queue of 32-bit units; word counts are derived
  // from queue length (A: 2 units per write, 1 per read; B: the reverse).
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ma_data = '0;
  logic        ma_valid = 0, ma_ovf = 0, ma_udf = 0, mb_ovf = 0, mb_udf = 0;
  bit          started = 0;
  int          n_err = 0;
  int          n_checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int fa(); return (64 - qa.size()) / 2; endfunction
  function automatic int va(); return qa.size();            endfunction
  function automatic int fb(); return 64 - qb.size();       endfunction
  function automatic int vb(); return qb.size() / 2;        endfunction

  task automatic model_update();
    bit a_f, a_e, b_f, b_e;
    a_f = (fa() == 0); a_e = (va() == 0);
    b_f = (fb() == 0); b_e = (vb() == 0);
    if (rst) begin
      qa.delete(); qb.delete();
      ma_data = '0; ma_valid = 0; ma_ovf = 0; ma_udf = 0; mb_ovf = 0; mb_udf = 0;
    end else begin
      if (a_wr_en && a_f && !a_flush) ma_ovf = 1; else if (a_clr) ma_ovf = 0;
      if (a_rd_en && a_e && !a_flush) ma_udf = 1; else if (a_clr) ma_udf = 0;
      if (a_flush) begin
        qa.delete(); ma_valid = 0;
      end else begin
        ma_valid = a_rd_en && !a_e;
        if (ma_valid) ma_data = qa.pop_front();
        if (a_wr_en && !a_f) begin qa.push_back(a_wd[31:0]); qa.push_back(a_wd[63:32]); end
      end
      if (b_wr_en && b_f && !b_flush) mb_ovf = 1; else if (b_clr) mb_ovf = 0;
      if (b_rd_en && b_e && !b_flush) mb_udf = 1; else if (b_clr) mb_udf = 0;
      if (b_flush) begin
        qb.delete();
      end else begin
        if (b_rd_en && !b_e) begin void'(qb.pop_front()); void'(qb.pop_front()); end
        if (b_wr_en && !b_f) qb.push_back(b_wd);
      end
    end
  endtask

  task automatic compare();
    chk("a_full",   64'(a_full),   64'(fa() == 0));
    chk("a_free",   64'(a_free),   64'(fa()));
    chk("a_afull",  64'(a_afull),  64'(fa() <= 4));
    chk("a_ovf",    64'(a_ovf),    64'(ma_ovf));
    chk("a_empty",  64'(a_empty),  64'(va() == 0));
    chk("a_avail",  64'(a_avail),  64'(va()));
    chk("a_aempty", 64'(a_aempty), 64'(va() <= 4));
    chk("a_udf",    64'(a_udf),    64'(ma_udf));
    chk("a_valid",  64'(a_valid),  64'(ma_valid));
    chk("a_data",   64'(a_data),   64'(ma_data));
    chk("b_full",   64'(b_full),   64'(fb() == 0));
    chk("b_free",   64'(b_free),   64'(fb()));
    chk("b_afull",  64'(b_afull),  64'(fb() <= 4));
    chk("b_ovf",    64'(b_ovf),    64'(mb_ovf));
    chk("b_empty",  64'(b_empty),  64'(vb() == 0));
    chk("b_avail",  64'(b_avail),  64'(vb()));
    chk("b_aempty", 64'(b_aempty), 64'(vb() <= 4));
    chk("b_udf",    64'(b_udf),    64'(mb_udf));
    chk("b_valid",  64'(b_valid),  64'(vb() > 0));
    if (vb() > 0) chk("b_data", b_data, {qb[1], qb[0]});
  endtask

  // One clock: inputs held across the rising edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (started) compare();
  endtask

  initial begin
    @(negedge clk);
    rst = 1; step(); started = 1; step(); rst = 0;
    chk("rst_a_free",   64'(a_free),   64'd32);
    chk("rst_a_avail",  64'(a_avail),  64'd0);
    chk("rst_a_empty",  64'(a_empty),  64'd1);
    chk("rst_a_aempty", 64'(a_aempty), 64'd1);
    chk("rst_a_afull",  64'(a_afull),  64'd0);
    chk("rst_a_valid",  64'(a_valid),  64'd0);
    chk("rst_b_free",   64'(b_free),   64'd64);

    // one wide write, two narrow reads, low half first
    a_wr_en = 1; a_wd = 64'h1111_1111_2222_2222; step(); a_wr_en = 0;
    chk("wr1_avail", 64'(a_avail), 64'd2);
    a_rd_en = 1; step();
    chk("rd1_avail", 64'(a_avail), 64'd1);
    chk("rd1_data",  64'(a_data),  64'h2222_2222);
    chk("rd1_valid", 64'(a_valid), 64'd1);
    step();
    chk("rd2_avail", 64'(a_avail), 64'd0);
    chk("rd2_data",  64'(a_data),  64'h1111_1111);
    chk("rd2_valid", 64'(a_valid), 64'd1);
    a_rd_en = 0; step();
    chk("rd_idle_valid", 64'(a_valid), 64'd0);
    chk("rd_idle_data",  64'(a_data),  64'h1111_1111);

    // fill to full, watermark edge, overflow
    for (int i = 0; i < 32; i++) begin
      a_wr_en = 1; a_wd = {32'(101 + 2*i), 32'(100 + 2*i)}; step();
      if (i == 26) chk("afull_w27", 64'(a_afull), 64'd0);
      if (i == 27) begin
        chk("afull_w28", 64'(a_afull), 64'd1);
        chk("free_w28",  64'(a_free),  64'd4);
      end
    end
    chk("fill_full", 64'(a_full), 64'd1);
    chk("fill_free", 64'(a_free), 64'd0);
    a_wd = 64'hDEAD_BEEF_DEAD_BEEF; step(); a_wr_en = 0;
    chk("ovf_set",   64'(a_ovf),   64'd1);
    chk("ovf_avail", 64'(a_avail), 64'd64);
    a_clr = 1; step(); a_clr = 0;
    chk("ovf_clr", 64'(a_ovf), 64'd0);

    // full: write and read together -> write dropped, read taken
    a_wr_en = 1; a_rd_en = 1; step(); a_wr_en = 0; a_rd_en = 0;
    chk("wr_rd_full_ovf",   64'(a_ovf),   64'd1);
    chk("wr_rd_full_avail", 64'(a_avail), 64'd63);
    chk("wr_rd_full_free",  64'(a_free),  64'd0);
    chk("wr_rd_full_data",  64'(a_data),  64'd100);

    // flush with a write pending
    a_flush = 1; a_wr_en = 1; step(); a_flush = 0; a_wr_en = 0;
    chk("flush_avail", 64'(a_avail), 64'd0);
    chk("flush_free",  64'(a_free),  64'd32);
    chk("flush_ovf",   64'(a_ovf),   64'd1);
    chk("flush_data",  64'(a_data),  64'd100);
    a_clr = 1; step(); a_clr = 0;

    // underflow, set beats clear
    a_rd_en = 1; step();
    chk("udf_set",   64'(a_udf),   64'd1);
    chk("udf_valid", 64'(a_valid), 64'd0);
    a_clr = 1; step();
    chk("udf_set_vs_clr", 64'(a_udf), 64'd1);
    a_rd_en = 0; step(); a_clr = 0;
    chk("udf_clr", 64'(a_udf), 64'd0);

    // mixed traffic checked by the model
    for (int i = 0; i < 24; i++) begin
      a_wr_en = (i % 3) != 2;
      a_rd_en = ((i % 4) == 3) || (i > 15);
      a_wd = {32'(i*7 + 5), 32'(i*3)};
      step();
    end
    a_rd_en = 0;

    // reset mid-operation
    a_wr_en = 1; a_wd = 64'h0123_4567_89AB_CDEF; step(); a_wr_en = 0;
    a_rd_en = 1; step(); a_rd_en = 0;
    rst = 1; step(); rst = 0;
    chk("mrst_free",  64'(a_free),  64'd32);
    chk("mrst_data",  64'(a_data),  64'd0);
    chk("mrst_avail", 64'(a_avail), 64'd0);

    // FWFT, 32 -> 64
    b_wr_en = 1; b_wd = 32'hAAAA_AAAA; step();
    chk("fwft_half_empty", 64'(b_empty), 64'd1);
    b_wd = 32'hBBBB_BBBB; step(); b_wr_en = 0;
    chk("fwft_data",  b_data,           64'hBBBB_BBBB_AAAA_AAAA);
    chk("fwft_valid", 64'(b_valid),     64'd1);
    b_rd_en = 1; step(); b_rd_en = 0;
    chk("fwft_pop_valid", 64'(b_valid), 64'd0);

    // FWFT fill, overflow, simultaneous pop/push
    for (int i = 0; i < 65; i++) begin
      b_wr_en = 1; b_wd = 32'(32'h5000_0000 + i); step();
    end
    b_wr_en = 0;
    chk("fwft_full", 64'(b_full), 64'd1);
    chk("fwft_ovf",  64'(b_ovf),  64'd1);
    b_wr_en = 1; b_rd_en = 1; b_wd = 32'hCAFE_0000; step();
    chk("fwft_wr_rd_data", b_data, 64'h5000_0003_5000_0002);
    step(); b_wr_en = 0; b_rd_en = 0;
    b_flush = 1; step(); b_flush = 0;
    chk("fwft_flush_avail", 64'(b_avail), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
